// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, FSM states, S-box tables and byte helpers
package aes_pkg;
  localparam int AES128 = 128;
  localparam int AES192 = 192;
  localparam int AES256 = 256;
  typedef logic [127:0] block_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nr_of(input int n);
    return n / 32 + 6;
  endfunction
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [0:255][7:0] invert(input logic [0:255][7:0] t);
    logic [0:255][7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) r[t[i]] = 8'(i);
    return r;
  endfunction
  localparam logic [0:255][7:0] INV_SBOX = invert(SBOX);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // byte i of a block in FIPS input order (byte 0 in the MSBs)
  function automatic logic [7:0] bat(input block_t b, input int i);
    return b[127-8*i -: 8];
  endfunction
endpackage

// File: rtl/addRoundKey.sv
// addRoundKey: xors the round key into the state
module addRoundKey (
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  output logic [127:0] o_state
);
  assign o_state = i_state ^ i_rk;
endmodule

// File: rtl/aes_dec_round.sv
// aes_dec_round: one inverse round; invMixColumns is skipped on the last round
module aes_dec_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_last,
  output logic [127:0] o_state
);
  logic [127:0] w_isb, w_ark, w_imc;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign w_isb[127-8*(4*c+r) -: 8] = INV_SBOX[bat(i_state, 4*((c+4-r)%4)+r)];
      assign w_imc[127-8*(4*c+r) -: 8] = gmul(bat(w_ark, 4*c+r), 4'd14) ^
        gmul(bat(w_ark, 4*c+(r+1)%4), 4'd11) ^ gmul(bat(w_ark, 4*c+(r+2)%4), 4'd13) ^
        gmul(bat(w_ark, 4*c+(r+3)%4), 4'd9);
    end
  end
  assign w_ark = w_isb ^ i_rk;
  assign o_state = i_last ? w_ark : w_imc;
endmodule

// File: rtl/encryptRound.sv
// encryptRound: one full forward round (subBytes, shiftRows, mixColumns, addRoundKey)
module encryptRound
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  output logic [127:0] o_state
);
  logic [127:0] w_sb, w_sr, w_mc;
  subBytes u_sb (.i_state(i_state), .o_state(w_sb));
  shiftRows u_sr (.i_state(w_sb), .o_state(w_sr));
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign w_mc[127-8*(4*c+r) -: 8] = xt(bat(w_sr, 4*c+r)) ^ xt(bat(w_sr, 4*c+(r+1)%4)) ^
        bat(w_sr, 4*c+(r+1)%4) ^ bat(w_sr, 4*c+(r+2)%4) ^ bat(w_sr, 4*c+(r+3)%4);
    end
  end
  addRoundKey u_ark (.i_state(w_mc), .i_rk(i_rk), .o_state(o_state));
endmodule

// File: rtl/keyExpansion.sv
// keyExpansion: full AES key schedule, round key 0 in the MSBs
module keyExpansion
  import aes_pkg::*;
#(
  parameter int N = 128
) (
  input  logic [N-1:0]                  i_key,
  output logic [128*(nr_of(N)+1)-1:0]   o_sched
);
  localparam int NK = N / 32;
  localparam int NW = 4 * (nr_of(N) + 1);
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction
  function automatic logic [32*NW-1:0] expand(input logic [N-1:0] kin);
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0] rc;
    logic [32*NW-1:0] s;
    rc = 8'h01;
    for (int i = 0; i < NK; i++) w[i] = kin[N-1-32*i -: 32];
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (NK > 6 && i % NK == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    for (int i = 0; i < NW; i++) s[32*(NW-i)-1 -: 32] = w[i];
    return s;
  endfunction
  assign o_sched = expand(i_key);
endmodule

// File: rtl/shiftRows.sv
// shiftRows: rotates row r of the state left by r bytes
module shiftRows (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign o_state[127-8*(4*c+r) -: 8] = i_state[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

// File: rtl/subBytes.sv
// subBytes: forward S-box applied to every byte of the state
module subBytes
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign o_state[127-8*i -: 8] = SBOX[i_state[127-8*i -: 8]];
  end
endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 core, one round per clock, encrypt or decrypt per block
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int N = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [N-1:0] key,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam int Nk = N / 32;
  localparam int Nr = Nk + 6;
  localparam int CW = $clog2(Nr + 1);
  if (N != AES128 && N != AES192 && N != AES256) begin : g_bad_n
    $error("aes_iter_core: N must be 128, 192 or 256");
  end
  state_t r_st;
  logic r_key_ok, r_dec, r_out_valid, w_last;
  logic [CW-1:0] r_cnt;
  block_t r_state, r_out_data, w_rk_enc, w_rk_dec, w_enc_mid, w_enc_fin, w_sb, w_sr, w_dec, w_next;
  logic [0:Nr][127:0] r_sched, w_sched;
  keyExpansion #(.N(N)) u_kx (.i_key(key), .o_sched(w_sched));
  assign w_last = r_cnt == CW'(Nr);
  assign w_rk_enc = r_sched[r_cnt];
  assign w_rk_dec = r_sched[CW'(Nr) - r_cnt];
  encryptRound u_er (.i_state(r_state), .i_rk(w_rk_enc), .o_state(w_enc_mid));
  // final forward round drops mixColumns
  subBytes u_sb (.i_state(r_state), .o_state(w_sb));
  shiftRows u_sr (.i_state(w_sb), .o_state(w_sr));
  addRoundKey u_ark (.i_state(w_sr), .i_rk(w_rk_enc), .o_state(w_enc_fin));
  aes_dec_round u_dr (.i_state(r_state), .i_rk(w_rk_dec), .i_last(w_last), .o_state(w_dec));
  assign w_next = r_dec ? w_dec : (w_last ? w_enc_fin : w_enc_mid);
  assign key_ready = r_st == IDLE;
  assign in_ready = key_ready && r_key_ok && !key_load;
  assign out_valid = r_out_valid;
  assign out_data = r_out_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= IDLE;
      r_key_ok <= 1'b0;
      r_dec <= 1'b0;
      r_cnt <= '0;
      r_state <= '0;
      r_sched <= '0;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
    end else begin
      case (r_st)
        IDLE: begin
          if (key_load) begin
            r_sched <= w_sched;
            r_key_ok <= 1'b1;
          end else if (in_valid && r_key_ok) begin
            r_state <= in_data ^ (in_decrypt ? r_sched[Nr] : r_sched[0]);
            r_dec <= in_decrypt;
            r_cnt <= CW'(1);
            r_st <= RUN;
          end
        end
        RUN: begin
          r_state <= w_next;
          if (w_last) begin
            r_out_data <= w_next;
            r_out_valid <= 1'b1;
            r_st <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_cnt <= '0;
            r_st <= IDLE;
          end
        end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule
